// File: rtl/pe_simd_mac_if.sv
// ---------------------------------------------------------------------------
// pe_simd_mac_if
// Bundle of the configuration, input-beat and result signals of pe_simd_mac.
//   master : job/stream source (drives cfg_*, in_*, out_ready)
//   slave  : the processing element (drives in_ready, out_*, busy)
// Signals:
//   cfg_start/cfg_len/cfg_bias/cfg_shift/cfg_relu : job configuration
//   in_valid/in_ready/in_act/in_wgt               : packed lane beats, lane 0 in LSBs
//   out_valid/out_ready/out_act/out_acc/out_sat   : requantised result
//   busy                                          : element not idle
// ---------------------------------------------------------------------------
interface pe_simd_mac_if #(
    parameter int N_LANES   = 4,
    parameter int IN_WIDTH  = 8,
    parameter int ACC_WIDTH = 32,
    parameter int ACT_WIDTH = 8,
    parameter int LEN_WIDTH = 16
) ();
    logic                          cfg_start;
    logic [LEN_WIDTH-1:0]          cfg_len;
    logic [ACC_WIDTH-1:0]          cfg_bias;
    logic [7:0]                    cfg_shift;
    logic                          cfg_relu;
    logic                          in_valid;
    logic                          in_ready;
    logic [N_LANES*IN_WIDTH-1:0]   in_act;
    logic [N_LANES*IN_WIDTH-1:0]   in_wgt;
    logic                          out_valid;
    logic                          out_ready;
    logic [ACT_WIDTH-1:0]          out_act;
    logic [ACC_WIDTH-1:0]          out_acc;
    logic                          out_sat;
    logic                          busy;

    modport master (
        output cfg_start, cfg_len, cfg_bias, cfg_shift, cfg_relu,
        output in_valid, in_act, in_wgt, out_ready,
        input  in_ready, out_valid, out_act, out_acc, out_sat, busy
    );

    modport slave (
        input  cfg_start, cfg_len, cfg_bias, cfg_shift, cfg_relu,
        input  in_valid, in_act, in_wgt, out_ready,
        output in_ready, out_valid, out_act, out_acc, out_sat, busy
    );
endinterface

// File: rtl/pe_simd_mac.sv
// ---------------------------------------------------------------------------
// pe_simd_mac
// SIMD multiply/accumulate processing element. Each accepted beat carries
// N_LANES signed activation/weight pairs; all lanes are multiplied (stage 1),
// reduced and added to the accumulator (stage 2). After cfg_len beats the
// accumulator is requantised (arithmetic right shift, optional ReLU,
// saturation to ACT_WIDTH) and presented on a valid/ready result port.
// Ports:
//   clk   : clock
//   reset : asynchronous active-low reset
//   bus   : pe_simd_mac_if.slave (cfg_*, in_* beat stream, out_* result, busy)
// Build option:
//   PE_SIMD_ROUND_NEAREST_EN : when defined, requantisation rounds half toward
//   +inf (adds 2^(shift-1) before shifting); otherwise it floors.
// ---------------------------------------------------------------------------
module pe_simd_mac #(
    parameter int N_LANES   = 4,
    parameter int IN_WIDTH  = 8,
    parameter int ACC_WIDTH = 32,
    parameter int ACT_WIDTH = 8,
    parameter int LEN_WIDTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    pe_simd_mac_if.slave  bus
);

    localparam int PW   = 2 * IN_WIDTH;
    localparam int RQ_W = ACC_WIDTH + 1;

    // Saturation bounds, sign-extended to the requantisation width.
    localparam logic signed [RQ_W-1:0] SAT_MAX =
        {{(RQ_W-ACT_WIDTH+1){1'b0}}, {(ACT_WIDTH-1){1'b1}}};
    localparam logic signed [RQ_W-1:0] SAT_MIN =
        {{(RQ_W-ACT_WIDTH+1){1'b1}}, {(ACT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, OUT} state_t;

    state_t                        state_reg;
    logic [LEN_WIDTH-1:0]          len_q;
    logic [LEN_WIDTH-1:0]          beat_cnt_reg;
    logic [7:0]                    shift_q;
    logic                          relu_q;
    logic signed [ACC_WIDTH-1:0]   acc_reg;
    logic signed [PW-1:0]          prod_reg  [N_LANES];
    logic signed [PW-1:0]          prod_next [N_LANES];
    logic                          p1_valid_reg;
    logic                          drain_cnt_reg;
    logic                          out_valid_reg;
    logic [ACT_WIDTH-1:0]          out_act_reg;
    logic [ACC_WIDTH-1:0]          out_acc_reg;
    logic                          out_sat_reg;

    logic                          in_ready_int;
    logic                          beat_xfer;
    logic signed [ACC_WIDTH-1:0]   lane_sum;

    logic signed [RQ_W-1:0]        rq_base;
    logic signed [RQ_W-1:0]        rq_shifted;
    logic signed [RQ_W-1:0]        rq_relu;
    logic [31:0]                   shift_ext;
    logic [31:0]                   shift_eff;
    logic [ACT_WIDTH-1:0]          rq_act_next;
    logic                          rq_sat_next;

    // Ready depends only on registered state, so it never combinationally
    // follows in_valid.
    assign in_ready_int = (state_reg == ACC) && (beat_cnt_reg < len_q);
    assign beat_xfer    = bus.in_valid && in_ready_int;

    // Stage 1 multipliers, one per lane.
    generate
        for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
            logic signed [IN_WIDTH-1:0] a_lane;
            logic signed [IN_WIDTH-1:0] w_lane;
            assign a_lane        = bus.in_act[gi*IN_WIDTH +: IN_WIDTH];
            assign w_lane        = bus.in_wgt[gi*IN_WIDTH +: IN_WIDTH];
            assign prod_next[gi] = PW'(a_lane) * PW'(w_lane);
        end
    endgenerate

    // Stage 2 reduction: sign-extend every product to accumulator width.
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < N_LANES; i++) begin
            lane_sum = lane_sum + ACC_WIDTH'(prod_reg[i]);
        end
    end

    // Requantisation, evaluated one bit wider than the accumulator so the
    // rounding addend cannot wrap.
    always_comb begin
        rq_base   = {acc_reg[ACC_WIDTH-1], acc_reg};
        shift_ext = {24'd0, shift_q};
`ifdef PE_SIMD_ROUND_NEAREST_EN
        // Beyond ACC_WIDTH the addend no longer fits; the shift alone then
        // yields the sign fill.
        if (shift_q != 8'd0 && shift_ext <= 32'(ACC_WIDTH)) begin
            rq_base = rq_base + (RQ_W'(1) << (shift_q - 8'd1));
        end
`endif
        // Shifting the widened value by ACC_WIDTH already leaves only sign
        // bits, so larger amounts are clamped there.
        shift_eff  = (shift_ext >= 32'(ACC_WIDTH)) ? 32'(ACC_WIDTH) : shift_ext;
        rq_shifted = rq_base >>> shift_eff;
        rq_relu    = (relu_q && rq_shifted[RQ_W-1]) ? '0 : rq_shifted;
        if (rq_relu > SAT_MAX) begin
            rq_act_next = SAT_MAX[ACT_WIDTH-1:0];
            rq_sat_next = 1'b1;
        end else if (rq_relu < SAT_MIN) begin
            rq_act_next = SAT_MIN[ACT_WIDTH-1:0];
            rq_sat_next = 1'b1;
        end else begin
            rq_act_next = rq_relu[ACT_WIDTH-1:0];
            rq_sat_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            len_q         <= '0;
            beat_cnt_reg  <= '0;
            shift_q       <= '0;
            relu_q        <= 1'b0;
            acc_reg       <= '0;
            p1_valid_reg  <= 1'b0;
            drain_cnt_reg <= 1'b0;
            out_valid_reg <= 1'b0;
            out_act_reg   <= '0;
            out_acc_reg   <= '0;
            out_sat_reg   <= 1'b0;
            for (int i = 0; i < N_LANES; i++) begin
                prod_reg[i] <= '0;
            end
        end else begin
            p1_valid_reg <= beat_xfer;
            if (beat_xfer) begin
                for (int i = 0; i < N_LANES; i++) begin
                    prod_reg[i] <= prod_next[i];
                end
            end

            // The pipeline is always empty in IDLE, so loading the bias can
            // never collide with a pending stage-2 add.
            if (state_reg == IDLE && bus.cfg_start) begin
                acc_reg <= bus.cfg_bias;
            end else if (p1_valid_reg) begin
                acc_reg <= acc_reg + lane_sum;
            end

            case (state_reg)
                IDLE: begin
                    if (bus.cfg_start) begin
                        len_q         <= bus.cfg_len;
                        shift_q       <= bus.cfg_shift;
                        relu_q        <= bus.cfg_relu;
                        beat_cnt_reg  <= '0;
                        drain_cnt_reg <= 1'b0;
                        state_reg     <= (bus.cfg_len != '0) ? ACC : DRAIN;
                    end
                end
                ACC: begin
                    if (beat_xfer) begin
                        beat_cnt_reg <= beat_cnt_reg + LEN_WIDTH'(1);
                        if (beat_cnt_reg == len_q - LEN_WIDTH'(1)) begin
                            drain_cnt_reg <= 1'b0;
                            state_reg     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // First cycle lets stage 2 fold in the last beat; second
                    // cycle captures the final accumulator into the outputs.
                    drain_cnt_reg <= 1'b1;
                    if (drain_cnt_reg) begin
                        out_act_reg   <= rq_act_next;
                        out_acc_reg   <= acc_reg;
                        out_sat_reg   <= rq_sat_next;
                        out_valid_reg <= 1'b1;
                        state_reg     <= OUT;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_act   = out_act_reg;
    assign bus.out_acc   = out_acc_reg;
    assign bus.out_sat   = out_sat_reg;
    assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_pe_simd_mac.sv
// ---------------------------------------------------------------------------
// tb_pe_simd_mac
// Directed self-checking bench for pe_simd_mac with hand-computed results:
// basic accumulate, saturation both ways, reset mid-job, zero-length jobs
// with and without ReLU, backpressure on both ports, requantisation rounding
// (expected value follows PE_SIMD_ROUND_NEAREST_EN).
// ---------------------------------------------------------------------------
module tb_pe_simd_mac;

    localparam int N_LANES   = 4;
    localparam int IN_WIDTH  = 8;
    localparam int ACC_WIDTH = 32;
    localparam int ACT_WIDTH = 8;
    localparam int LEN_WIDTH = 16;
    localparam int DW        = N_LANES * IN_WIDTH;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pe_simd_mac_if #(
        .N_LANES(N_LANES), .IN_WIDTH(IN_WIDTH), .ACC_WIDTH(ACC_WIDTH),
        .ACT_WIDTH(ACT_WIDTH), .LEN_WIDTH(LEN_WIDTH)
    ) bus ();

    pe_simd_mac #(
        .N_LANES(N_LANES), .IN_WIDTH(IN_WIDTH), .ACC_WIDTH(ACC_WIDTH),
        .ACT_WIDTH(ACT_WIDTH), .LEN_WIDTH(LEN_WIDTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input logic signed [63:0] got,
                               input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int len, input int bias, input int shift, input bit relu);
        bus.cfg_len   = LEN_WIDTH'(len);
        bus.cfg_bias  = ACC_WIDTH'(bias);
        bus.cfg_shift = 8'(shift);
        bus.cfg_relu  = relu;
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
    endtask

    // One complete job: start, feed beats, check latency, stall the result,
    // check data, then handshake with a (to-be-ignored) start pulse.
    task automatic run_job(input string tag, input int len, input int bias,
                           input int shift, input bit relu,
                           input logic [DW-1:0] act_pk, input logic [DW-1:0] wgt_pk,
                           input bit toggle, input int stall,
                           input int exp_acc, input int exp_act, input bit exp_sat);
        int beats;
        int extra;
        int guard;
        start_job(len, bias, shift, relu);
        bus.in_act = act_pk;
        bus.in_wgt = wgt_pk;
        if (len == 0) begin
            tick();
            check_value({tag, "_valid_early"}, 64'(bus.out_valid), 0);
            tick();
            check_value({tag, "_valid_lat"}, 64'(bus.out_valid), 1);
        end else begin
            beats = 0;
            guard = 0;
            while (beats < len && guard < 200) begin
                bus.in_valid  = toggle ? (guard % 2 == 0) : 1'b1;
                // Start pulses mid-job must be ignored.
                bus.cfg_start = toggle && (guard == 1);
                bus.cfg_len   = LEN_WIDTH'(9);
                if (bus.in_valid && bus.in_ready) beats++;
                tick();
                guard++;
            end
            bus.cfg_start = 1'b0;
            check_value({tag, "_beats"}, 64'(beats), 64'(len));
            check_value({tag, "_ready_off"}, 64'(bus.in_ready), 0);
            // Keep offering beats during the drain; none may be taken.
            extra = 0;
            bus.in_valid = 1'b1;
            if (bus.in_ready) extra++;
            tick();
            check_value({tag, "_valid_early"}, 64'(bus.out_valid), 0);
            if (bus.in_ready) extra++;
            tick();
            bus.in_valid = 1'b0;
            check_value({tag, "_extra_beats"}, 64'(extra), 0);
            check_value({tag, "_valid_lat"}, 64'(bus.out_valid), 1);
        end
        bus.out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            bus.cfg_start = (i == 2);
            check_value({tag, "_stall_valid"}, 64'(bus.out_valid), 1);
            check_value({tag, "_stall_act"}, $signed(bus.out_act), 64'(exp_act));
            tick();
        end
        bus.cfg_start = 1'b0;
        check_value({tag, "_acc"}, $signed(bus.out_acc), 64'(exp_acc));
        check_value({tag, "_act"}, $signed(bus.out_act), 64'(exp_act));
        check_value({tag, "_sat"}, 64'(bus.out_sat), 64'(exp_sat));
        bus.out_ready = 1'b1;
        bus.cfg_start = 1'b1;
        bus.cfg_len   = LEN_WIDTH'(0);
        tick();
        bus.out_ready = 1'b0;
        bus.cfg_start = 1'b0;
        check_value({tag, "_valid_drop"}, 64'(bus.out_valid), 0);
        check_value({tag, "_idle"}, 64'(bus.busy), 0);
        check_value({tag, "_act_held"}, $signed(bus.out_act), 64'(exp_act));
        $display("job %s: acc=%0d act=%0d sat=%0d", tag, $signed(bus.out_acc),
                 $signed(bus.out_act), bus.out_sat);
    endtask

    task automatic check_all_zero(input string tag);
        check_value({tag, "_out_valid"}, 64'(bus.out_valid), 0);
        check_value({tag, "_in_ready"}, 64'(bus.in_ready), 0);
        check_value({tag, "_busy"}, 64'(bus.busy), 0);
        check_value({tag, "_out_act"}, 64'(bus.out_act), 0);
        check_value({tag, "_out_acc"}, 64'(bus.out_acc), 0);
        check_value({tag, "_out_sat"}, 64'(bus.out_sat), 0);
    endtask

    int rnd_pos;
    int rnd_neg;
    int beats_rst;

    initial begin
        reset         = 1'b0;
        bus.cfg_start = 1'b0;
        bus.cfg_len   = '0;
        bus.cfg_bias  = '0;
        bus.cfg_shift = '0;
        bus.cfg_relu  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_act    = '0;
        bus.in_wgt    = '0;
        bus.out_ready = 1'b0;
        #1;
        check_all_zero("reset");
        tick();
        tick();
        reset = 1'b1;
        tick();

        // 3 beats of lanes 1*{1,2,3,4} = 10 each.
        run_job("basic", 3, 0, 0, 1'b0, 32'h01010101, 32'h04030201, 1'b0, 0, 30, 30, 1'b0);
        // 2 beats of 4*127*127; 129032 >>> 8 = 504 -> clamps to 127.
        run_job("sat_pos", 2, 0, 8, 1'b0, 32'h7F7F7F7F, 32'h7F7F7F7F, 1'b0, 0, 129032, 127, 1'b1);
        // 2 beats of 4*127*(-128); -130048 >>> 8 = -508 -> clamps to -128.
        run_job("sat_neg", 2, 0, 8, 1'b0, 32'h7F7F7F7F, 32'h80808080, 1'b0, 0, -130048, -128, 1'b1);

        // Abort a 5-beat job after 2 beats.
        start_job(5, 0, 0, 1'b0);
        bus.in_act   = 32'h01010101;
        bus.in_wgt   = 32'h01010101;
        beats_rst    = 0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            if (bus.in_ready) beats_rst++;
            tick();
        end
        bus.in_valid = 1'b0;
        check_value("abort_beats", 64'(beats_rst), 2);
        reset = 1'b0;
        #1;
        check_all_zero("midjob_reset");
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_value("abort_no_result", 64'(bus.out_valid), 0);
        run_job("post_reset", 3, 0, 0, 1'b0, 32'h01010101, 32'h04030201, 1'b0, 0, 30, 30, 1'b0);

        run_job("zero_relu", 0, -50, 0, 1'b1, '0, '0, 1'b0, 0, -50, 0, 1'b0);
        run_job("zero_norelu", 0, -50, 0, 1'b0, '0, '0, 1'b0, 0, -50, -50, 1'b0);

        // Lanes act {3,-2,5,1} x wgt {2,4,-3,1} = -16 per beat; 10 - 64 = -54;
        // -54 >>> 1 = -27 (exact, both rounding modes).
        run_job("backpress", 4, 10, 1, 1'b0, 32'h0105FE03, 32'h01FD0402, 1'b1, 5, -54, -27, 1'b0);

`ifdef PE_SIMD_ROUND_NEAREST_EN
        rnd_pos = 2;
        rnd_neg = -1;
`else
        rnd_pos = 1;
        rnd_neg = -2;
`endif
        run_job("round_pos", 0, 384, 8, 1'b0, '0, '0, 1'b0, 0, 384, rnd_pos, 1'b0);
        run_job("round_neg", 0, -384, 8, 1'b0, '0, '0, 1'b0, 0, -384, rnd_neg, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pe_simd_mac.md
Name: pe_simd_mac

Overview:
Parametrised next-generation processing element for the MAC engine array. Each input beat carries N_LANES parallel activation/weight pairs, all multiplied and accumulated in one beat. The block runs a pipelined multiply/reduce/accumulate over a programmed number of beats, starting from a bias. It then requantises the accumulator (arithmetic shift, optional ReLU, saturation to ACT_WIDTH) and hands the result out over a valid/ready interface. It replaces per-cycle control-line MAC sequencing with an internal FSM.

Parameters:
N_LANES, 4, parallel multiplier lanes per beat (power of two, >=1)
IN_WIDTH, 8, signed activation/weight width per lane
ACC_WIDTH, 32, signed accumulator width (>= 2*IN_WIDTH+clog2(N_LANES))
ACT_WIDTH, 8, signed output activation width
LEN_WIDTH, 16, width of beat-count configuration

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-low reset
cfg_start  input  1  start pulse; accepted only in IDLE
cfg_len  input  LEN_WIDTH  number of input beats to accumulate
cfg_bias  input  ACC_WIDTH  signed accumulator initial value
cfg_shift  input  8  right-shift amount for requantisation
cfg_relu  input  1  1 = clamp negative results to 0
in_valid  input  1  input beat valid
in_ready  output  1  input beat ready
in_act  input  N_LANES*IN_WIDTH  packed signed activations, lane 0 in LSBs
in_wgt  input  N_LANES*IN_WIDTH  packed signed weights, lane 0 in LSBs
out_valid  output  1  result valid
out_ready  input  1  result ready
out_act  output  ACT_WIDTH  requantised, saturated activation
out_acc  output  ACC_WIDTH  raw accumulator value at end of job
out_sat  output  1  1 = saturation applied to out_act
busy  output  1  high in any state except IDLE

Behaviour:
- Reset (asynchronous, active-low): FSM to IDLE; accumulator, beat counter and pipeline valid cleared; in_ready=0, out_valid=0, out_act=0, out_acc=0, out_sat=0, busy=0. Reset mid-job aborts the job; no partial result is emitted.
- FSM states: IDLE, ACC, DRAIN, OUT.
- IDLE: on cfg_start, latch cfg_len, cfg_shift and cfg_relu; set acc=cfg_bias and beat_cnt=0. Go to ACC if cfg_len!=0, else DRAIN. cfg_start in any other state is ignored.
- ACC: in_ready = (beat_cnt < len_q). A beat transfers when in_valid&in_ready. When the last beat transfers, go to DRAIN; in_ready is 0 from the next cycle.
- Pipeline stage 1 registers N_LANES signed products (2*IN_WIDTH each) plus a valid bit. Stage 2 adds the sign-extended lane sum to acc. acc wraps modulo 2^ACC_WIDTH; no accumulator saturation.
- DRAIN: lasts exactly 2 cycles, for pipeline flush and the requant register load. Then go to OUT.
- Requantisation: sh = acc >>> cfg_shift (arithmetic shift); shift >= ACC_WIDTH gives all sign bits. If relu_q and sh<0, then sh=0. Saturate to [-2^(ACT_WIDTH-1), 2^(ACT_WIDTH-1)-1]; out_sat=1 iff clamped. out_acc = acc.
- Latency: if the last beat transfers in cycle c, out_valid=1 from cycle c+3. With cfg_len=0 and start in cycle s, out_valid=1 from cycle s+3.
- OUT: out_valid=1. out_act, out_acc and out_sat are held stable until out_valid&out_ready. The cycle after the handshake: IDLE, out_valid=0, data outputs keep their last value.
- cfg_start in the same cycle as the OUT handshake is ignored (not IDLE yet). It is accepted the following cycle.

Optional Feature:
Macro PE_SIMD_ROUND_NEAREST_EN.
- Defined: when cfg_shift>0, add 2^(cfg_shift-1) to acc before the arithmetic shift (round half toward +inf). The addition is done in ACC_WIDTH+1 bits so it cannot wrap.
- Undefined: plain arithmetic shift (floor).
- ReLU and saturation apply after rounding in both cases.

Test Plan:
- Basic accumulate: N=4, bias=0, len=3, shift=0, act lanes all 1, wgt lanes {1,2,3,4}, in_valid held 1 -> out_acc=30, out_act=30, out_sat=0. out_valid first high 3 cycles after the last beat handshake.
- Saturation: act=127, wgt=127 all lanes, len=2, shift=8 -> out_acc=129032, out_act=127, out_sat=1. Repeat with wgt=-128 -> out_acc=-130048, out_act=-128, out_sat=1.
- ReLU + zero length: len=0, bias=-50, relu=1 -> out_acc=-50, out_act=0, out_sat=0, out_valid at start+3. Same with relu=0 -> out_act=-50.
- Backpressure: in_valid toggled 1/0 each cycle for len=4, out_ready low 5 cycles -> exactly 4 beats accepted. Outputs stable while stalled; cfg_start pulses while busy ignored.
- Rounding: len=0, shift=8, bias=384 -> out_act=1 without the macro, 2 with it. Bias=-384 -> -2 without, -1 with.
- Reset mid-job: assert reset after 2 of 5 beats -> all outputs 0 immediately, busy=0. A new job after reset produces a correct result, with no residue from the aborted job.
